// File: rtl/gate_pkg.sv
// gate_pkg: gate function encodings, FSM states and truth tables shared by the checker
package gate_pkg;
   localparam int NPAT = 4;
   typedef enum logic [2:0] {
      G_AND, G_OR, G_NAND, G_NOR, G_XOR, G_XNOR, G_NOT_A, G_BUF_A
   } gate_e;
   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_FINISH} state_e;
   // bit i of each entry is the expected output for pattern {a,b}=i
   localparam logic [NPAT-1:0] GATE_TT [8] = '{
      4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1100
   };
endpackage

// File: rtl/gate_pattern_checker_if.sv
// gate_pattern_checker_if: control, status and gate-under-test signals of the checker
interface gate_pattern_checker_if;
   import gate_pkg::*;
   logic start;
   logic [2:0] gate_sel;
   logic a;
   logic b;
   logic y;
   logic busy;
   logic done;
   logic pass;
   logic [2:0] err_count;
   logic [NPAT-1:0] fail_vec;
   modport master (output start, gate_sel, y, input a, b, busy, done, pass, err_count, fail_vec);
   modport slave (input start, gate_sel, y, output a, b, busy, done, pass, err_count, fail_vec);
endinterface

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational expected output of the selected two-input gate
module gate_ref_model
   import gate_pkg::*;
(
   input  gate_e sel,
   input  logic  a,
   input  logic  b,
   output logic  y_exp
);
   assign y_exp = GATE_TT[sel][{a, b}];
endmodule

// File: rtl/gate_pattern_checker.sv
// gate_pattern_checker: drives all four {a,b} patterns for DWELL cycles each and scores the gate response
module gate_pattern_checker
   import gate_pkg::*;
#(
   parameter int DWELL = 4
) (
   input logic clk,
   input logic rst,
   gate_pattern_checker_if.slave bus
);
   localparam int CW = $clog2(DWELL + 1);
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
   state_e state_q, state_d;
   gate_e sel_q, sel_d;
   logic [1:0] pat_q, pat_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] err_q, err_d;
   logic [NPAT-1:0] fail_q, fail_d;
   logic pass_q, pass_d;
   logic y_exp;
   gate_ref_model u_ref (.sel(sel_q), .a(pat_q[1]), .b(pat_q[0]), .y_exp(y_exp));
   always_comb begin
      state_d = state_q;
      sel_d = sel_q;
      pat_d = pat_q;
      cnt_d = cnt_q;
      err_d = err_q;
      fail_d = fail_q;
      pass_d = pass_q;
      case (state_q)
         S_IDLE: if (bus.start) begin
            state_d = S_DRIVE;
            sel_d = gate_e'(bus.gate_sel);
            err_d = '0;
            fail_d = '0;
            pat_d = '0;
            cnt_d = '0;
         end
         S_DRIVE: if (cnt_q == LAST) begin
            if (bus.y != y_exp) begin
               err_d = err_q + 3'd1;
               fail_d[pat_q] = 1'b1;
            end
            cnt_d = '0;
            pat_d = pat_q + 2'd1;
            // result is latched on the way into FINISH so pass is valid alongside done
            if (pat_q == 2'd3) begin
               state_d = S_FINISH;
               pass_d = (err_d == 3'd0);
            end
         end else cnt_d = cnt_q + CW'(1);
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sel_q <= G_AND;
         pat_q <= '0;
         cnt_q <= '0;
         err_q <= '0;
         fail_q <= '0;
         pass_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q <= sel_d;
         pat_q <= pat_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
         fail_q <= fail_d;
         pass_q <= pass_d;
      end
   end
   assign bus.a = pat_q[1];
   assign bus.b = pat_q[0];
   assign bus.busy = (state_q == S_DRIVE);
   assign bus.done = (state_q == S_FINISH);
   assign bus.pass = pass_q;
   assign bus.err_count = err_q;
   assign bus.fail_vec = fail_q;
endmodule

// File: tb/tb_gate_pattern_checker.sv
// tb_gate_pattern_checker: scoreboard bench for DWELL=4 and DWELL=1 checkers with modelled gates under test
module tb_gate_pattern_checker;
   localparam int D4 = 4;
   typedef struct { int err; int fv; int pass; int cyc; } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int kind4 = 0;
   int kind1 = 0;
   int act4 = -1;
   exp_t hold4 = '{0, 0, 0, 0};
   exp_t q4[$];
   exp_t q1[$];
   gate_pattern_checker_if if4();
   gate_pattern_checker_if if1();
   gate_pattern_checker #(.DWELL(D4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
   gate_pattern_checker #(.DWELL(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic fn(int sel, logic a, logic b);
      case (sel)
         0: return a & b;
         1: return a | b;
         2: return ~(a & b);
         3: return ~(a | b);
         4: return a ^ b;
         5: return ~(a ^ b);
         6: return ~a;
         default: return a;
      endcase
   endfunction
   // kinds 0..7 behave like that gate, 8 is stuck at 0, 9 is stuck at 1
   function automatic logic gut(int kind, logic a, logic b);
      return (kind < 8) ? fn(kind, a, b) : (kind == 9);
   endfunction
   always_comb if4.y = gut(kind4, if4.a, if4.b);
   always_comb if1.y = gut(kind1, if1.a, if1.b);
   function automatic exp_t predict(int sel, int kind, int d, int n);
      exp_t e;
      logic pa, pb;
      e.err = 0;
      e.fv = 0;
      e.cyc = n + 1 + 4 * d;
      for (int p = 0; p < 4; p++) begin
         pa = p[1];
         pb = p[0];
         if (gut(kind, pa, pb) != fn(sel, pa, pb)) begin
            e.err++;
            e.fv |= 1 << p;
         end
      end
      e.pass = (e.err == 0) ? 1 : 0;
      return e;
   endfunction
   task automatic chk(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   always @(negedge clk) begin
      int k;
      exp_t e;
      k = cyc - act4;
      if (if4.done) begin
         if (q4.size() == 0) chk("done4_unexpected", 1, 0);
         else begin
            e = q4.pop_front();
            chk("done4_cycle", cyc, e.cyc);
            chk("err4", int'(if4.err_count), e.err);
            chk("fail4", int'(if4.fail_vec), e.fv);
            chk("pass4", int'(if4.pass), e.pass);
            hold4 = e;
         end
      end
      if (act4 >= 0 && k >= 1 && k <= 4 * D4) begin
         chk("busy4_run", int'(if4.busy), 1);
         chk("ab4_run", int'({if4.a, if4.b}), (k - 1) / D4);
      end else begin
         chk("busy4_idle", int'(if4.busy), 0);
         chk("ab4_idle", int'({if4.a, if4.b}), 0);
         chk("result4_hold", int'({if4.pass, if4.err_count, if4.fail_vec}),
             (hold4.pass << 7) | (hold4.err << 4) | hold4.fv);
      end
   end
   always @(negedge clk) begin
      exp_t e;
      if (if1.done) begin
         if (q1.size() == 0) chk("done1_unexpected", 1, 0);
         else begin
            e = q1.pop_front();
            chk("done1_cycle", cyc, e.cyc);
            chk("err1", int'(if1.err_count), e.err);
            chk("fail1", int'(if1.fail_vec), e.fv);
            chk("pass1", int'(if1.pass), e.pass);
         end
      end
   end
   task automatic go(input bit w, input int sel, input int kind, input int gap);
      int d;
      d = w ? 1 : D4;
      if (w) begin
         if1.gate_sel = 3'(sel);
         kind1 = kind;
         if1.start = 1'b1;
         q1.push_back(predict(sel, kind, 1, cyc));
      end else begin
         if4.gate_sel = 3'(sel);
         kind4 = kind;
         if4.start = 1'b1;
         act4 = cyc;
         q4.push_back(predict(sel, kind, D4, cyc));
      end
      tick();
      if1.start = 1'b0;
      if4.start = 1'b0;
      for (int i = 0; i < 4 * d + 1 + gap; i++) begin
         if (w) if1.gate_sel = 3'($urandom_range(0, 7));
         else if4.gate_sel = 3'($urandom_range(0, 7));
         tick();
      end
   endtask
   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
   initial begin
      int n;
      if4.start = 1'b0;
      if4.gate_sel = 3'd0;
      if1.start = 1'b0;
      if1.gate_sel = 3'd0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_done", int'(if4.done), 0);
      chk("rst_busy", int'(if4.busy), 0);
      chk("rst_pass", int'(if4.pass), 0);
      chk("rst_err", int'(if4.err_count), 0);
      chk("rst_fail", int'(if4.fail_vec), 0);
      chk("rst_ab", int'({if4.a, if4.b}), 0);
      go(0, 2, 2, 0);
      go(0, 2, 8, 1);
      go(0, 4, 0, 2);
      go(0, 7, 7, 0);
      // abort a run while pattern 10 is on the pins
      n = cyc;
      if4.gate_sel = 3'd3;
      kind4 = 1;
      if4.start = 1'b1;
      act4 = n;
      tick();
      if4.start = 1'b0;
      repeat (2 * D4) tick();
      chk("pre_rst_ab", int'({if4.a, if4.b}), 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      act4 = -1;
      hold4 = '{0, 0, 0, 0};
      chk("abort_busy", int'(if4.busy), 0);
      chk("abort_done", int'(if4.done), 0);
      chk("abort_pass", int'(if4.pass), 0);
      repeat (3) tick();
      go(0, 3, 3, 0);
      // start held high across two runs with gate_sel changing mid-run
      n = cyc;
      if4.gate_sel = 3'd2;
      kind4 = 5;
      if4.start = 1'b1;
      act4 = n;
      q4.push_back(predict(2, 5, D4, n));
      tick();
      tick();
      if4.gate_sel = 3'd5;
      repeat (4 * D4) tick();
      act4 = cyc;
      q4.push_back(predict(5, 5, D4, cyc));
      tick();
      if4.start = 1'b0;
      if4.gate_sel = 3'd0;
      repeat (4 * D4 + 2) tick();
      repeat (20) go(0, $urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 3));
      go(1, 4, 4, 0);
      go(1, 4, 8, 1);
      repeat (12) go(1, $urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 2));
      for (int i = 0; i < 100 && (q4.size() + q1.size()) > 0; i++) tick();
      chk("drain", q4.size() + q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
